// File: rtl/sqrt_result_buffer_if.sv
// Valid/ready handshake bundle between the sqrt datapath, the result buffer
// and the writeback arbiter.
interface sqrt_result_buffer_if #(
  parameter int unsigned bits     = 32,
  parameter int unsigned tag_bits = 5
);
  logic                in_valid;
  logic [bits-1:0]     in_data;
  logic [tag_bits-1:0] in_tag;
  logic                in_ready;
  logic                out_valid;
  logic [bits-1:0]     out_data;
  logic [tag_bits-1:0] out_tag;
  logic                out_ready;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/sqrt_result_buffer.sv
// Two-entry skid buffer between the sqrt result registers and core writeback.
// Strict FIFO order, with a synchronous flush that takes priority over push and pop.
module sqrt_result_buffer #(
  parameter int unsigned bits     = 32,
  parameter int unsigned tag_bits = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  sqrt_result_buffer_if.slave  bus,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  logic [bits-1:0]     head_data;
  logic [tag_bits-1:0] head_tag;
  logic [bits-1:0]     tail_data;
  logic [tag_bits-1:0] tail_tag;
  logic                push;
  logic                pop;

  // Every output is a register or a pure decode of state, so there is no
  // combinational path from the input handshake through to the output handshake.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = head_data;
  assign bus.out_tag   = head_tag;
  assign occupancy     = state;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head_data <= '0;
      head_tag  <= '0;
      tail_data <= '0;
      tail_tag  <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      head_data <= '0;
      head_tag  <= '0;
      tail_data <= '0;
      tail_tag  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_data <= bus.in_data;
            head_tag  <= bus.in_tag;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_data <= bus.in_data;
              tail_tag  <= bus.in_tag;
              state     <= FULL;
            end
            2'b01: begin
              head_data <= '0;
              head_tag  <= '0;
              state     <= EMPTY;
            end
            2'b11: begin
              head_data <= bus.in_data;
              head_tag  <= bus.in_tag;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head_data <= tail_data;
            head_tag  <= tail_tag;
            tail_data <= '0;
            tail_tag  <= '0;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_result_buffer.sv
// Scoreboard bench for sqrt_result_buffer: expected entries are queued at push
// and compared when the buffer hands them to writeback.
module tb_sqrt_result_buffer;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } ent_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occupancy;
  int         checks;
  int         fails;
  ent_t       q[$];

  sqrt_result_buffer_if #(.bits(32), .tag_bits(5)) bus ();

  sqrt_result_buffer #(.bits(32), .tag_bits(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] d, input logic [4:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_tag !== 5'd0) begin fails++; $display("FAIL reset_out_tag: got %0d want 0", bus.out_tag); end
  endtask

  task automatic test_single();
    ent_t e;
    bus.out_ready = 1'b1;
    drive_in(1'b1, 32'h0000_0010, 5'd5);
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    q.push_back({5'd5, 32'h0000_0010});
    tick();
    drive_in(1'b0, 32'h0, 5'd0);
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++; if (bus.out_data !== e.data) begin fails++; $display("FAIL single_data: got %h want %h", bus.out_data, e.data); end
      checks++; if (bus.out_tag !== e.tag) begin fails++; $display("FAIL single_tag: got %0d want %0d", bus.out_tag, e.tag); end
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b want 0", bus.out_valid); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL single_drain_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure();
    ent_t e;
    int   popped;
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h0000_0009, 5'd3);
    q.push_back({5'd3, 32'h0000_0009});
    tick();
    drive_in(1'b1, 32'h0000_0004, 5'd7);
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_second_ready: got %b want 1", bus.in_ready); end
    q.push_back({5'd7, 32'h0000_0004});
    tick();
    drive_in(1'b1, 32'h0000_0001, 5'd1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL bp_full_occ: got %0d want 2", occupancy); end
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h9 || bus.out_tag !== 5'd3) begin fails++; $display("FAIL bp_stable_head: got %h/%0d want 9/3", bus.out_data, bus.out_tag); end
      tick();
    end
    bus.out_ready = 1'b1;
    popped = 0;
    for (int cyc = 0; cyc < 10 && popped < 3; cyc++) begin
      if (bus.in_valid && bus.in_ready) q.push_back({bus.in_tag, bus.in_data});
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        checks++;
        if (q.size() == 0) begin fails++; $display("FAIL bp_unexpected: got %h/%0d want none", bus.out_data, bus.out_tag); end
        else begin
          e = q.pop_front();
          if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin fails++; $display("FAIL bp_order: got %h/%0d want %h/%0d", bus.out_data, bus.out_tag, e.data, e.tag); end
        end
      end
      tick();
      if (bus.in_valid && q.size() != 0 && q[q.size()-1].data == 32'h1) drive_in(1'b0, 32'h0, 5'd0);
    end
    drive_in(1'b0, 32'h0, 5'd0);
    checks++; if (popped != 3) begin fails++; $display("FAIL bp_pop_count: got %0d want 3", popped); end
    checks++; if (q.size() != 0) begin fails++; $display("FAIL bp_leftover: got %0d want 0", q.size()); end
  endtask

  task automatic test_streaming();
    ent_t e;
    int   popped;
    bus.out_ready = 1'b1;
    popped = 0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) drive_in(1'b1, 32'(i), 5'(i));
      else drive_in(1'b0, 32'h0, 5'd0);
      if (i > 1) begin
        checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL stream_occ: got %0d want 1", occupancy); end
        checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_bubble: got %b want 1", bus.out_valid); end
      end
      if (bus.in_valid && bus.in_ready) q.push_back({bus.in_tag, bus.in_data});
      if (bus.out_valid && bus.out_ready) begin
        popped++;
        checks++;
        if (q.size() == 0) begin fails++; $display("FAIL stream_unexpected: got %h want none", bus.out_data); end
        else begin
          e = q.pop_front();
          if (bus.out_data !== e.data || bus.out_tag !== e.tag) begin fails++; $display("FAIL stream_order: got %h/%0d want %h/%0d", bus.out_data, bus.out_tag, e.data, e.tag); end
        end
      end
      tick();
    end
    checks++; if (popped != 8) begin fails++; $display("FAIL stream_count: got %0d want 8", popped); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stream_drained: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    ent_t e;
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'hA, 5'd10);
    q.push_back({5'd10, 32'hA});
    tick();
    drive_in(1'b1, 32'hB, 5'd11);
    q.push_back({5'd11, 32'hB});
    tick();
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_prefill: got %0d want 2", occupancy); end
    drive_in(1'b1, 32'hC, 5'd12);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    // The head is consumed by writeback in the flush cycle; everything else is discarded.
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++; if (bus.out_data !== e.data) begin fails++; $display("FAIL flush_head: got %h want %h", bus.out_data, e.data); end
    end
    q.delete();
    tick();
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 5'd0);
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL flush_data: got %h want 0", bus.out_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped: got valid %b data %h want 0", bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive_in(1'b1, 32'h11, 5'd1);
    tick();
    drive_in(1'b1, 32'h22, 5'd2);
    tick();
    drive_in(1'b0, 32'h0, 5'd0);
    checks++; if (occupancy !== 2'd2) begin fails++; $display("FAIL areset_prefill: got %0d want 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", bus.out_valid); end
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_data !== 32'h0 || bus.out_tag !== 5'd0) begin fails++; $display("FAIL areset_head: got %h/%0d want 0/0", bus.out_data, bus.out_tag); end
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL areset_release: got %0d want 0", occupancy); end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 5'd0);
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
